avr_dmem_arbiter: RTL and testbench

AVR_DMEM_ARBITER -- requirements
Module: avr_dmem_arbiter

---
 rtl/avr_dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_avr_dmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_dmem_arbiter.sv
// AVR data-memory arbiter: the CPU always wins the single memory port, and
// DMA requests slip into the idle cycles. A blocked DMA request is tracked
// so that long waits raise a sticky starvation flag. A saturating counter
// records how many DMA accesses have been issued.
module avr_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        starve,
  output logic [15:0] gnt_count
);

  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  WAIT    = 1'b1;
  localparam logic [15:0] LIMIT16 = 16'(STARVE_LIMIT);
  localparam logic [15:0] SAT16   = 16'hFFFF;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;
  logic [15:0] addr_hold;
  logic [7:0]  wdata_hold;
  logic        rvalid_q;
  logic        starve_q;
  logic [15:0] gnt_cnt_q;
  logic        cpu_active;
  logic        dma_access;

  assign cpu_active = cpu_wen | cpu_ren;
  assign dma_access = ~cpu_active & dma_req;

  // Read data goes straight back to both masters; only the valid strobe
  // tells the DMA side that the byte belongs to it. The strobe is masked
  // while reset is low so a read granted just before reset never shows up.
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = rvalid_q & reset;
  assign starve     = starve_q;
  assign gnt_count  = gnt_cnt_q;

  // Memory port mux: CPU first, then DMA, otherwise park on the last address/data.
  always_comb begin
    dma_gnt   = reset & dma_access;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_active) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = reset & cpu_wen;
      mem_ren   = reset & cpu_ren;
    end else if (dma_req) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wen   = reset & dma_we;
      mem_ren   = reset & ~dma_we;
    end
  end

  // Wait tracking: a DMA request blocked by the CPU moves to WAIT and stays
  // there until it is served or (illegally) withdrawn.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (dma_req & cpu_active) ? WAIT : IDLE;
      WAIT:    state_next = (dma_req & cpu_active) ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
    wait_next = wait_cnt;
    if (state_next == IDLE) begin
      wait_next = 16'h0000;
    end else if ((state == WAIT) && cpu_active && (wait_cnt != SAT16)) begin
      wait_next = wait_cnt + 16'h0001;
    end
  end

  // State, counters, flags and the parked address/data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= 16'h0000;
      starve_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      gnt_cnt_q  <= 16'h0000;
      addr_hold  <= 16'h0000;
      wdata_hold <= 8'h00;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      starve_q <= starve_q | (wait_next == LIMIT16);
      rvalid_q <= dma_gnt & ~dma_we;
      if (dma_gnt && (gnt_cnt_q != SAT16)) begin
        gnt_cnt_q <= gnt_cnt_q + 16'h0001;
      end
      if (cpu_active | dma_req) begin
        addr_hold  <= mem_addr;
        wdata_hold <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Testbench for avr_dmem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the arbiter.
module tb_avr_dmem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_wen;
  logic        cpu_ren;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        starve;
  logic [15:0] gnt_count;

  avr_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .starve(starve), .gnt_count(gnt_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the DMA "is waiting" once the CPU has blocked it,
  // m_wait counts further blocked cycles, everything else is bookkeeping.
  bit          m_pending  = 1'b0;
  int          m_wait     = 0;
  bit          m_starve   = 1'b0;
  int          m_gnt      = 0;
  bit          m_rvalid   = 1'b0;
  logic [15:0] m_addr     = 16'h0000;
  logic [7:0]  m_wdata    = 8'h00;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, then moves to the falling edge.
  task automatic applyStimulus(input logic [15:0] ca, input logic cw, input logic cr,
                               input logic [7:0] cwd, input logic dr, input logic dw,
                               input logic [15:0] da, input logic [7:0] dwd,
                               input logic [7:0] mrd);
    cpu_addr  = ca;
    cpu_wen   = cw;
    cpu_ren   = cr;
    cpu_wdata = cwd;
    dma_req   = dr;
    dma_we    = dw;
    dma_addr  = da;
    dma_wdata = dwd;
    mem_rdata = mrd;
    #4;
  endtask

  task automatic checkAll();
    logic act;
    logic e_gnt;
    act   = cpu_wen | cpu_ren;
    e_gnt = reset & !act & dma_req;
    checkFlag("dma_gnt", dma_gnt, e_gnt);
    checkFlag("mem_wen", mem_wen, reset & (act ? cpu_wen : (dma_req & dma_we)));
    checkFlag("mem_ren", mem_ren, reset & (act ? cpu_ren : (dma_req & !dma_we)));
    if (reset) begin
      checkOutput("mem_addr", mem_addr, act ? cpu_addr : (dma_req ? dma_addr : m_addr));
      checkOutput("mem_wdata", {8'h00, mem_wdata},
                  {8'h00, act ? cpu_wdata : (dma_req ? dma_wdata : m_wdata)});
    end
    checkFlag("dma_rvalid", dma_rvalid, reset & m_rvalid);
    if (reset && m_rvalid) checkOutput("dma_rdata", {8'h00, dma_rdata}, {8'h00, mem_rdata});
    checkOutput("cpu_rdata", {8'h00, cpu_rdata}, {8'h00, mem_rdata});
    checkFlag("starve", starve, m_starve);
    checkOutput("gnt_count", gnt_count, 16'(m_gnt));
  endtask

  task automatic updateModel();
    logic act;
    logic gnt;
    act = cpu_wen | cpu_ren;
    gnt = !act & dma_req;
    if (!reset) begin
      m_pending = 1'b0;
      m_wait    = 0;
      m_starve  = 1'b0;
      m_gnt     = 0;
      m_rvalid  = 1'b0;
      m_addr    = 16'h0000;
      m_wdata   = 8'h00;
    end else begin
      m_rvalid = gnt & !dma_we;
      if (gnt && m_gnt < 65535) m_gnt++;
      if (act) begin
        m_addr  = cpu_addr;
        m_wdata = cpu_wdata;
      end else if (dma_req) begin
        m_addr  = dma_addr;
        m_wdata = dma_wdata;
      end
      if (act && dma_req) begin
        if (m_pending && m_wait < 65535) m_wait++;
        m_pending = 1'b1;
      end else begin
        m_pending = 1'b0;
        m_wait    = 0;
      end
      if (m_wait >= int'(LIMIT)) m_starve = 1'b1;
    end
  endtask

  task automatic runCycle();
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic idleCycle(input logic [7:0] mrd);
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, mrd);
    runCycle();
  endtask

  task automatic doReset();
    reset = 1'b0;
    idleCycle(8'h00);
    idleCycle(8'h00);
    reset = 1'b1;
  endtask

  initial begin
    bit          req_pend;
    logic        rdw;
    logic [15:0] rda;
    logic [7:0]  rdwd;
    logic        rcw;
    logic        rcr;
    int unsigned sel;
    logic        granted;

    // Reset with both masters requesting: nothing may reach memory.
    reset = 1'b0;
    applyStimulus(16'h1234, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 16'h4321, 8'h22, 8'h00);
    @(posedge clk);
    updateModel();
    #1;
    applyStimulus(16'h1234, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 16'h4321, 8'h22, 8'h00);
    checkFlag("rst_mem_wen", mem_wen, 1'b0);
    checkFlag("rst_dma_gnt", dma_gnt, 1'b0);
    checkOutput("rst_gnt_count", gnt_count, 16'h0000);
    checkFlag("rst_starve", starve, 1'b0);
    runCycle();
    reset = 1'b1;

    // CPU read only.
    applyStimulus(16'h0100, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    checkFlag("cpurd_ren", mem_ren, 1'b1);
    checkOutput("cpurd_addr", mem_addr, 16'h0100);
    checkFlag("cpurd_gnt", dma_gnt, 1'b0);
    runCycle();
    applyStimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0, 8'h5A);
    checkOutput("cpurd_data", {8'h00, cpu_rdata}, 16'h005A);
    runCycle();

    // DMA write with the CPU idle.
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 16'h0200, 8'hC3, 8'h00);
    checkFlag("dmawr_gnt", dma_gnt, 1'b1);
    checkFlag("dmawr_wen", mem_wen, 1'b1);
    checkOutput("dmawr_addr", mem_addr, 16'h0200);
    checkOutput("dmawr_wdata", {8'h00, mem_wdata}, 16'h00C3);
    runCycle();
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    checkOutput("dmawr_count", gnt_count, 16'h0001);
    checkOutput("hold_addr", mem_addr, 16'h0200);
    runCycle();

    // Collision: CPU write wins, DMA read follows in the next idle cycle.
    applyStimulus(16'h0010, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 16'h0020, 8'h00, 8'h00);
    checkOutput("coll_addr", mem_addr, 16'h0010);
    checkFlag("coll_ren", mem_ren, 1'b0);
    checkFlag("coll_gnt", dma_gnt, 1'b0);
    runCycle();
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 16'h0020, 8'h00, 8'h00);
    checkFlag("coll_gnt2", dma_gnt, 1'b1);
    checkFlag("coll_ren2", mem_ren, 1'b1);
    checkOutput("coll_addr2", mem_addr, 16'h0020);
    runCycle();
    // DMA read data arrives while the CPU already starts its own read.
    applyStimulus(16'h0030, 1'b0, 1'b1, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h77);
    checkFlag("coll_rvalid", dma_rvalid, 1'b1);
    checkOutput("coll_rdata", {8'h00, dma_rdata}, 16'h0077);
    checkOutput("coll_cpu_rdata", {8'h00, cpu_rdata}, 16'h0077);
    runCycle();
    idleCycle(8'h3C);

    // Starvation: CPU busy six cycles while the DMA read waits.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(16'h0040, 1'b0, 1'b1, 8'h0, 1'b1, 1'b0, 16'h0050, 8'h0, 8'h00);
      if (k == 4) checkFlag("starve_early", starve, 1'b0);
      if (k == 6) checkFlag("starve_set", starve, 1'b1);
      runCycle();
    end
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 16'h0050, 8'h0, 8'h00);
    checkFlag("starve_gnt", dma_gnt, 1'b1);
    runCycle();
    idleCycle(8'h00);
    checkFlag("starve_sticky", starve, 1'b1);

    // Reset right after a granted DMA read.
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 16'h0060, 8'h0, 8'h00);
    runCycle();
    reset = 1'b0;
    applyStimulus(16'h0070, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 16'h0060, 8'h0, 8'h00);
    checkFlag("rstmid_wen", mem_wen, 1'b0);
    checkFlag("rstmid_ren", mem_ren, 1'b0);
    checkFlag("rstmid_rvalid", dma_rvalid, 1'b0);
    runCycle();
    applyStimulus(16'h0070, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 16'h0060, 8'h0, 8'h00);
    checkOutput("rstmid_count", gnt_count, 16'h0000);
    checkFlag("rstmid_starve", starve, 1'b0);
    runCycle();
    reset = 1'b1;
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    checkFlag("rstmid_rvalid_after", dma_rvalid, 1'b0);
    runCycle();

    // Withdrawn request while waiting must restart the wait count.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(16'h0080, 1'b0, 1'b1, 8'h0, 1'b1, 1'b1, 16'h0090, 8'h55, 8'h00);
      runCycle();
    end
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h00);
    checkFlag("viol_wen", mem_wen, 1'b0);
    checkFlag("viol_gnt", dma_gnt, 1'b0);
    runCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'h0080, 1'b0, 1'b1, 8'h0, 1'b1, 1'b1, 16'h0090, 8'h55, 8'h00);
      runCycle();
    end
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 16'h0090, 8'h55, 8'h00);
    checkFlag("viol_no_starve", starve, 1'b0);
    runCycle();

    // Random traffic honouring the hold-until-granted DMA protocol.
    req_pend = 1'b0;
    rdw = 1'b0; rda = 16'h0; rdwd = 8'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!req_pend && ($urandom_range(1, 0) != 0)) begin
        req_pend = 1'b1;
        rdw  = 1'($urandom_range(1, 0));
        rda  = 16'($urandom);
        rdwd = 8'($urandom);
      end
      sel = $urandom_range(3, 0);
      rcw = (sel == 0);
      rcr = (sel == 1);
      reset = ($urandom_range(199, 0) != 0);
      applyStimulus(16'($urandom), rcw, rcr, 8'($urandom), req_pend, rdw, rda, rdwd, 8'($urandom));
      granted = reset & req_pend & !(rcw | rcr);
      runCycle();
      if (granted) req_pend = 1'b0;
    end
    reset = 1'b1;

    // Grant counter saturation.
    doReset();
    applyStimulus(16'h0, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1, 16'h0ABC, 8'h99, 8'h00);
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clk);
      updateModel();
      #1;
      if (i == 65534) checkOutput("sat_fffe", gnt_count, 16'hFFFE);
      if (i == 65535) checkOutput("sat_ffff", gnt_count, 16'hFFFF);
    end
    checkOutput("sat_nowrap", gnt_count, 16'hFFFF);
    checkOutput("sat_model", gnt_count, 16'(m_gnt));
    idleCycle(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
